// File: rtl/turn_signal_pkg.sv
// Shared definitions for the turn-signal sequencer and the lamp-driver block.
package turn_signal_pkg;

  localparam int unsigned MAX_LAMPS = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEFT    = 3'd1,
    RIGHT   = 3'd2,
    HAZ_ON  = 3'd3,
    HAZ_OFF = 3'd4,
    ERR     = 3'd5
  } state_t;

  // Lamps 0..step lit, clipped to the number of lamps fitted.
  function automatic logic [MAX_LAMPS-1:0] fill_mask(input int unsigned step,
                                                     input int unsigned lamps);
    logic [MAX_LAMPS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LAMPS; i++) begin
      m[i] = (i <= step) && (i < lamps);
    end
    return m;
  endfunction

endpackage

// File: rtl/turn_signal_seq_if.sv
// Driver-switch requests and lamp outputs of the turn-signal sequencer.
interface turn_signal_seq_if #(
  parameter int LAMPS = 3
);
  logic             left;
  logic             right;
  logic             hazard;
  logic [LAMPS-1:0] l_signal;
  logic [LAMPS-1:0] r_signal;
  logic             error;

  modport master (output left, right, hazard, input l_signal, r_signal, error);
  modport slave  (input left, right, hazard, output l_signal, r_signal, error);
endinterface

// File: rtl/ts_dwell_timer.sv
// Counts DWELL cycles per lamp phase; clr restarts the phase.
module ts_dwell_timer #(
  parameter int DWELL = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic phase_end
);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [DW-1:0] dwell;

  assign phase_end = (dwell == DW'(DWELL - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell <= '0;
    end else if (clr || phase_end) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + DW'(1);
    end
  end
endmodule

// File: rtl/turn_signal_seq.sv
// Sequential turn-signal controller with hazard mode and left/right conflict error.
module turn_signal_seq
  import turn_signal_pkg::*;
#(
  parameter int LAMPS = 3,
  parameter int DWELL = 3
) (
  input logic              clk,
  input logic              rst_n,
  turn_signal_seq_if.slave bus
);
  localparam int SW = (LAMPS > 1) ? $clog2(LAMPS) : 1;

  typedef logic [LAMPS-1:0] lamp_t;

  state_t        state, next_state;
  logic [SW-1:0] step, next_step;
  logic          phase_end;
  logic          clr;
  lamp_t         fm;
  lamp_t         l_dec, r_dec;
  logic          err_dec;

  // Any state or step change restarts the dwell count.
  assign clr = (next_state != state) || (next_step != step);

  ts_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= next_state;
      step  <= next_step;
    end
  end

  always_comb begin
    next_state = state;
    next_step  = step;
    l_dec      = '0;
    r_dec      = '0;
    err_dec    = 1'b0;
    fm         = lamp_t'(fill_mask(32'(step), LAMPS));

    case (state)
      IDLE: begin
        next_step = '0;
        if (bus.hazard)                  next_state = HAZ_ON;
        else if (bus.left && bus.right)  next_state = ERR;
        else if (bus.left)               next_state = LEFT;
        else if (bus.right)              next_state = RIGHT;
      end
      LEFT, RIGHT: begin
        if (bus.hazard) begin
          next_state = HAZ_ON;
          next_step  = '0;
        end else if (phase_end) begin
          if (bus.left && bus.right) begin
            next_state = ERR;
            next_step  = '0;
          end else if ((step < SW'(LAMPS - 1)) &&
                       ((state == LEFT) ? bus.left : bus.right)) begin
            next_step = step + SW'(1);
          end else begin
            next_state = IDLE;
            next_step  = '0;
          end
        end
      end
      HAZ_ON, HAZ_OFF: begin
        if (phase_end) begin
          if (bus.hazard) next_state = (state == HAZ_ON) ? HAZ_OFF : HAZ_ON;
          else            next_state = IDLE;
        end
      end
      ERR: begin
        if (bus.hazard)                  next_state = HAZ_ON;
        else if (!(bus.left && bus.right)) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_step  = '0;
      end
    endcase

    case (state)
      LEFT:   l_dec = fm;
      RIGHT: begin
        for (int unsigned i = 0; i < LAMPS; i++) begin
          r_dec[i] = fm[LAMPS-1-i];
        end
      end
      HAZ_ON: begin
        l_dec = '1;
        r_dec = '1;
      end
      ERR:     err_dec = 1'b1;
      default: ;
    endcase
  end

  assign bus.l_signal = l_dec;
  assign bus.r_signal = r_dec;
  assign bus.error    = err_dec;
endmodule

// File: tb/tb_turn_signal_seq.sv
// Scenario bench for turn_signal_seq: LAMPS=3/DWELL=3 and LAMPS=5/DWELL=1 instances.
module tb_turn_signal_seq;
  typedef struct packed {
    logic [4:0] l;
    logic [4:0] r;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t sb[$];

  turn_signal_seq_if #(.LAMPS(3)) a ();
  turn_signal_seq_if #(.LAMPS(5)) b ();

  turn_signal_seq #(.LAMPS(3), .DWELL(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  turn_signal_seq #(.LAMPS(5), .DWELL(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

  always #5 clk = ~clk;

  // s = {rst_n, hazard, left, right}
  task automatic drive_a(input logic [3:0] s);
    rst_n    = s[3];
    a.hazard = s[2];
    a.left   = s[1];
    a.right  = s[0];
  endtask

  task automatic push_a(input logic [6:0] x);
    sb.push_back('{l: {2'b00, x[6:4]}, r: {2'b00, x[3:1]}, e: x[0]});
  endtask

  task automatic test_reset();
    exp_t e;
    drive_a(4'b0000);
    b.left = 1'b0; b.right = 1'b0; b.hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{l: '0, r: '0, e: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      compared++;
      if ({a.l_signal, a.r_signal, a.error, b.l_signal, b.r_signal, b.error} !==
          {e.l[2:0], e.r[2:0], e.e, e.l, e.r, e.e}) begin
        mismatched++;
        $display("FAIL reset cyc %0d: got a=%b/%b/%b b=%b/%b/%b want all zero", i,
                 a.l_signal, a.r_signal, a.error, b.l_signal, b.r_signal, b.error);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_left_held();
    logic [6:0] ex [14] = '{7'b001_000_0, 7'b001_000_0, 7'b001_000_0,
                            7'b011_000_0, 7'b011_000_0, 7'b011_000_0,
                            7'b111_000_0, 7'b111_000_0, 7'b111_000_0,
                            7'b000_000_0, 7'b001_000_0, 7'b001_000_0,
                            7'b001_000_0, 7'b000_000_0};
    exp_t e;
    for (int i = 0; i < 14; i++) begin
      drive_a((i < 12) ? 4'b1010 : 4'b1000);
      push_a(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      compared++;
      if ({a.l_signal, a.r_signal, a.error} !== {e.l[2:0], e.r[2:0], e.e}) begin
        mismatched++;
        $display("FAIL left_held cyc %0d: got l=%b r=%b e=%b want l=%b r=%b e=%b", i,
                 a.l_signal, a.r_signal, a.error, e.l[2:0], e.r[2:0], e.e);
      end
    end
  endtask

  task automatic test_right_pulse();
    logic [3:0] st [8] = '{4'b1001, 4'b1000, 4'b1000, 4'b1000,
                           4'b1001, 4'b1001, 4'b1000, 4'b1000};
    logic [6:0] ex [8] = '{7'b000_100_0, 7'b000_100_0, 7'b000_100_0, 7'b000_000_0,
                           7'b000_100_0, 7'b000_100_0, 7'b000_100_0, 7'b000_000_0};
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      drive_a(st[i]);
      push_a(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      compared++;
      if ({a.l_signal, a.r_signal, a.error} !== {e.l[2:0], e.r[2:0], e.e}) begin
        mismatched++;
        $display("FAIL right_pulse cyc %0d: got l=%b r=%b e=%b want l=%b r=%b e=%b", i,
                 a.l_signal, a.r_signal, a.error, e.l[2:0], e.r[2:0], e.e);
      end
    end
  endtask

  task automatic test_conflict();
    logic [3:0] st [5] = '{4'b1011, 4'b1011, 4'b1011, 4'b1010, 4'b1000};
    logic [6:0] ex [5] = '{7'b000_000_1, 7'b000_000_1, 7'b000_000_1,
                           7'b000_000_0, 7'b000_000_0};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drive_a(st[i]);
      push_a(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      compared++;
      if ({a.l_signal, a.r_signal, a.error} !== {e.l[2:0], e.r[2:0], e.e}) begin
        mismatched++;
        $display("FAIL conflict cyc %0d: got l=%b r=%b e=%b want l=%b r=%b e=%b", i,
                 a.l_signal, a.r_signal, a.error, e.l[2:0], e.r[2:0], e.e);
      end
    end
  endtask

  task automatic test_hazard();
    logic [6:0] ex [16] = '{7'b001_000_0, 7'b001_000_0, 7'b001_000_0,
                            7'b011_000_0, 7'b011_000_0,
                            7'b111_111_0, 7'b111_111_0, 7'b111_111_0,
                            7'b000_000_0, 7'b000_000_0, 7'b000_000_0,
                            7'b111_111_0, 7'b111_111_0, 7'b111_111_0,
                            7'b000_000_0, 7'b000_000_0};
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      drive_a((i < 5) ? 4'b1010 : (i < 12) ? 4'b1100 : 4'b1000);
      push_a(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      compared++;
      if ({a.l_signal, a.r_signal, a.error} !== {e.l[2:0], e.r[2:0], e.e}) begin
        mismatched++;
        $display("FAIL hazard cyc %0d: got l=%b r=%b e=%b want l=%b r=%b e=%b", i,
                 a.l_signal, a.r_signal, a.error, e.l[2:0], e.r[2:0], e.e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] st [15] = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
                            4'b1001, 4'b1001, 4'b0001, 4'b1001, 4'b1001,
                            4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b1000};
    logic [6:0] ex [15] = '{7'b000_100_0, 7'b000_100_0, 7'b000_100_0,
                            7'b000_110_0, 7'b000_110_0, 7'b000_110_0,
                            7'b000_111_0, 7'b000_000_0,
                            7'b000_100_0, 7'b000_100_0, 7'b000_100_0,
                            7'b000_110_0, 7'b000_110_0, 7'b000_110_0,
                            7'b000_000_0};
    exp_t e;
    for (int i = 0; i < 15; i++) begin
      drive_a(st[i]);
      push_a(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      compared++;
      if ({a.l_signal, a.r_signal, a.error} !== {e.l[2:0], e.r[2:0], e.e}) begin
        mismatched++;
        $display("FAIL reset_mid cyc %0d: got l=%b r=%b e=%b want l=%b r=%b e=%b", i,
                 a.l_signal, a.r_signal, a.error, e.l[2:0], e.r[2:0], e.e);
      end
    end
  endtask

  task automatic test_lamps5_dwell1();
    logic [4:0] exr [7] = '{5'b10000, 5'b11000, 5'b11100, 5'b11110,
                            5'b11111, 5'b00000, 5'b00000};
    exp_t e;
    drive_a(4'b1000);
    for (int i = 0; i < 7; i++) begin
      b.right = (i < 6);
      sb.push_back('{l: 5'b00000, r: exr[i], e: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      compared++;
      if ({b.l_signal, b.r_signal, b.error} !== {e.l, e.r, e.e}) begin
        mismatched++;
        $display("FAIL lamps5_dwell1 cyc %0d: got l=%b r=%b e=%b want l=%b r=%b e=%b", i,
                 b.l_signal, b.r_signal, b.error, e.l, e.r, e.e);
      end
    end
    b.right = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    a.left   = 1'b0; a.right = 1'b0; a.hazard = 1'b0;
    b.left   = 1'b0; b.right = 1'b0; b.hazard = 1'b0;
    @(negedge clk);
    test_reset();
    test_left_held();
    test_right_pulse();
    test_conflict();
    test_hazard();
    test_reset_mid();
    test_lamps5_dwell1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
